// File: rtl/karatsuba_clmul_seq_pkg.sv
// Shared GF(2) definitions: controller state encoding, default sizes and a
// bit-serial carry-less reference product used for self-checks.
package gf2_pkg;

  localparam int W_DEF     = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    MID,
    OUT
  } state_e;

  // Schoolbook carry-less product of the low n bits of x and y (n <= 64).
  function automatic logic [127:0] clmul_ref(input logic [63:0] x,
                                             input logic [63:0] y,
                                             input int          n);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < n && x[i]) r = r ^ ({64'd0, y} << i);
    end
    return r;
  endfunction

endpackage

// File: rtl/karatsuba_clmul_seq_if.sv
// Operand/result handshake bundle of the sequential carry-less multiplier.
interface karatsuba_clmul_seq_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-2:0] y;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/karatsuba_clmul_seq_clmul_half.sv
// Combinational H x H carry-less multiplier: AND array, XOR-reduced per column.
module clmul_half #(
  parameter int H = 4
) (
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  output logic [2*H-2:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < H; i++) begin
      for (int j = 0; j < H; j++) begin
        p[i+j] = p[i+j] ^ (x[i] & y[j]);
      end
    end
  end

endmodule

// File: rtl/karatsuba_clmul_seq.sv
// One-level Karatsuba carry-less W x W multiply, sharing a single half-width
// multiplier over three cycles (low, high, middle partials).
module karatsuba_clmul_seq
  import gf2_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  karatsuba_clmul_seq_if.slave bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_cnt
);

  localparam int H = W / 2;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-2:0]   z0_q, z0_d, z2_q, z2_d;
  logic [2*W-2:0] y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [H-1:0]   mx, my;
  logic [W-2:0]   prod, mid_sum;

  clmul_half #(.H(H)) u_half (
    .x(mx),
    .y(my),
    .p(prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = LO;
      LO:      state_d = HI;
      HI:      state_d = MID;
      MID:     state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == OUT);
    busy          = (state_q != IDLE);
    bus.y         = y_q;
    op_cnt        = cnt_q;
  end

  // Multiplier operands depend on state alone; IDLE/OUT feed zeros.
  always_comb begin
    mx = '0;
    my = '0;
    case (state_q)
      LO:  begin mx = a_q[H-1:0];            my = b_q[H-1:0];            end
      HI:  begin mx = a_q[W-1:H];            my = b_q[W-1:H];            end
      MID: begin mx = a_q[H-1:0] ^ a_q[W-1:H]; my = b_q[H-1:0] ^ b_q[W-1:H]; end
      default: ;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    z0_d    = z0_q;
    z2_d    = z2_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    mid_sum = prod ^ z0_q ^ z2_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin a_d = bus.a; b_d = bus.b; end
      LO:   z0_d = prod;
      HI:   z2_d = prod;
      MID:  y_d  = {z2_q, {W{1'b0}}}
                 ^ {{H{1'b0}}, mid_sum, {H{1'b0}}}
                 ^ {{W{1'b0}}, z0_q};
      OUT:  if (bus.out_ready) cnt_d = cnt_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      z0_q  <= '0;
      z2_q  <= '0;
      y_q   <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      z0_q  <= z0_d;
      z2_q  <= z2_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
    end
  end

  // The Karatsuba recombination must equal the schoolbook product.
  always @(posedge clk) begin
    if (!rst && state_q == MID)
      assert ({{(128-(2*W-1)){1'b0}}, y_d} ==
              clmul_ref({{(64-W){1'b0}}, a_q}, {{(64-W){1'b0}}, b_q}, W));
  end

endmodule

// File: tb/tb_karatsuba_clmul_seq.sv
// Directed-vector and randomized checks of the Karatsuba carry-less multiplier.
module tb_karatsuba_clmul_seq;
  import gf2_pkg::*;

  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             busy;
  logic [CNT_W-1:0] op_cnt;

  karatsuba_clmul_seq_if #(.W(W)) bus ();

  karatsuba_clmul_seq #(.W(W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-2:0] y;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [2*W-2:0] ref_y(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [127:0] r;
    r = clmul_ref({{(64-W){1'b0}}, a}, {{(64-W){1'b0}}, b}, W);
    return r[2*W-2:0];
  endfunction

  // One full transaction: wait gap cycles, offer operands, hold out_ready low
  // for `hold` cycles once the result appears, then complete the handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int gap, input int hold,
                        output logic [2*W-2:0] y_got, output int lat,
                        output int rdy_low, output bit stable);
    int guard;
    stable = 1'b1;
    repeat (gap) @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = ~a;
    bus.b        = a ^ b ^ 8'h5A;
    lat     = 1;
    rdy_low = bus.in_ready ? 0 : 1;
    while (!bus.out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
      if (!bus.in_ready) rdy_low++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 32'd0, 32'd1);
    y_got = bus.y;
    repeat (hold) begin
      bus.out_ready = 1'b0;
      @(negedge clk);
      if (!bus.out_valid || bus.y !== y_got || bus.in_ready) stable = 1'b0;
      if (!bus.in_ready) rdy_low++;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
  endtask

  initial begin
    logic [2*W-2:0] y_got;
    int             lat, rdy_low;
    bit             stable;
    int             bad_y, bad_cnt, bad_dup, bad_abort;
    bit             wrap_seen;
    logic [W-1:0]   ra, rb;
    logic [2*W-2:0] y_before;

    vecs[0] = '{8'hFF, 8'hFF, 15'h5555};
    vecs[1] = '{8'h80, 8'h80, 15'h4000};
    vecs[2] = '{8'h03, 8'h03, 15'h0005};
    vecs[3] = '{8'h0F, 8'hF0, 15'h0550};
    vecs[4] = '{8'h00, 8'hA7, 15'h0000};
    vecs[5] = '{8'h12, 8'h34, 15'h0328};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_busy",      {31'd0, busy},          32'd0);
    check("reset_y",         {17'd0, bus.y},         32'd0);
    check("reset_op_cnt",    {28'd0, op_cnt},        32'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, 0, 0, y_got, lat, rdy_low, stable);
      check($sformatf("vec%0d_y", i),       {17'd0, y_got},  {17'd0, vecs[i].y});
      check($sformatf("vec%0d_latency", i), lat,             32'd4);
      check($sformatf("vec%0d_rdy_low", i), rdy_low,         32'd4);
      check($sformatf("vec%0d_op_cnt", i),  {28'd0, op_cnt}, exp_cnt);
      check($sformatf("vec%0d_no_dup", i),  {31'd0, bus.out_valid}, 32'd0);
    end

    // Backpressure: result and flags must hold for 10 cycles.
    run_op(8'hA5, 8'h5A, 0, 10, y_got, lat, rdy_low, stable);
    check("bp_y",       {17'd0, y_got}, {17'd0, ref_y(8'hA5, 8'h5A)});
    check("bp_stable",  {31'd0, stable}, 32'd1);
    check("bp_rdy_low", rdy_low, 32'd14);
    check("bp_op_cnt",  {28'd0, op_cnt}, exp_cnt);
    @(negedge clk);
    check("bp_single_handshake", {28'd0, op_cnt}, exp_cnt);
    check("bp_out_valid_low",    {31'd0, bus.out_valid}, 32'd0);

    // Abort in HI via asynchronous reset between clock edges.
    bus.in_valid = 1'b1;
    bus.a        = 8'h55;
    bus.b        = 8'h33;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("abort_busy_in_hi", {31'd0, busy}, 32'd1);
    y_before = bus.y;
    #2 rst = 1'b1;
    #1;
    check("abort_y_nonzero_before", {31'd0, (y_before != '0)}, 32'd1);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_busy",      {31'd0, busy},          32'd0);
    check("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("abort_y",         {17'd0, bus.y},         32'd0);
    check("abort_op_cnt",    {28'd0, op_cnt},        32'd0);
    @(negedge clk);
    rst     = 1'b0;
    exp_cnt = 0;
    bad_abort = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid || busy) bad_abort++;
    end
    check("abort_no_result", bad_abort, 32'd0);
    run_op(8'h12, 8'h34, 0, 0, y_got, lat, rdy_low, stable);
    check("post_abort_y",      {17'd0, y_got},  32'h0328);
    check("post_abort_op_cnt", {28'd0, op_cnt}, 32'd1);

    // Randomized operands with random gaps; op_cnt wraps every 16 results.
    bad_y = 0; bad_cnt = 0; bad_dup = 0; wrap_seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, $urandom_range(0, 3), $urandom_range(0, 3), y_got, lat, rdy_low, stable);
      if (y_got !== ref_y(ra, rb) || !stable) bad_y++;
      if ({28'd0, op_cnt} !== exp_cnt) bad_cnt++;
      if (bus.out_valid) bad_dup++;
      if (exp_cnt == 0 && !wrap_seen) begin
        wrap_seen = 1'b1;
        check("op_cnt_wrap", {28'd0, op_cnt}, 32'd0);
      end
    end
    check("rand_y_errors",      bad_y,   32'd0);
    check("rand_op_cnt_errors", bad_cnt, 32'd0);
    check("rand_dup_results",   bad_dup, 32'd0);
    check("rand_wrap_reached",  {31'd0, wrap_seen}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/karatsuba_clmul_seq.md
Name: karatsuba_clmul_seq

Overview:
- Sequential controller for a carry-less (GF(2)) W×W multiply.
- Uses the one-level Karatsuba split and time-shares a single combinational half-width carry-less multiplier across three cycles (low, high, middle partials).
- Performs the XOR overlap-sum recombination and returns the (2W-1)-bit product over a valid/ready handshake.
- Sits between the operand source and the downstream XOR-reduction stages of the GF(2) arithmetic datapath.

Parameters:
- W, 8, operand width; must be even, ≥4. H = W/2.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  W  operand A, bit i = coefficient of x^i.
- b  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y  out  2W-1  carry-less product A·B.
- busy  out  1  high in every state except IDLE.
- op_cnt  out  CNT_W  completed handshakes, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst=1): state=IDLE; y=0; out_valid=0; busy=0; op_cnt=0; internal z0/z2/operand registers cleared. in_ready=1 once rst deasserts.
- Splits: aL=a[H-1:0], aH=a[W-1:H]; same for b.
- Partials, each 2H-1 bits:
  - z0 = aL·bL
  - z2 = aH·bH
  - zm = (aL^aH)·(bL^bH)
- Overlap sum: y = (z2<<W) ^ ((zm^z0^z2)<<H) ^ z0, zero-extended to 2W-1 bits. XOR only, no carries.
- FSM states: IDLE, LO, HI, MID, OUT.
  - IDLE: in_ready=1. On in_valid, capture a,b → LO.
  - LO: multiplier inputs aL,bL; register z0 → HI.
  - HI: multiplier inputs aH,bH; register z2 → MID.
  - MID: multiplier inputs (aL^aH),(bL^bH); register y from the current product plus z0/z2 → OUT.
  - OUT: out_valid=1, y held stable. On out_ready: op_cnt+1, → IDLE. Otherwise hold indefinitely; no result is lost or overwritten.
- Multiplier operand mux is driven only by the state. Inputs are don't-care in IDLE and OUT.
- in_ready = (state==IDLE). out_valid = (state==OUT). The two are never high in the same cycle.
- Latency: accept edge E0; out_valid high after edge E0+3. Max throughput: one operation per 5 cycles with out_ready tied high.
- a and b may change after acceptance without effect; captured copies are used.
- in_valid while busy is ignored and not queued. The source must hold in_valid until in_ready.
- op_cnt wraps from 2^CNT_W-1 to 0 without any flag.
- Reset asserted mid-operation aborts it immediately. No out_valid is produced for the aborted operand pair, and op_cnt is unchanged by it.
- y keeps its last value in IDLE. It is valid only while out_valid=1.

Decomposition:
- Shared package gf2_pkg holds:
  - state enum type (IDLE, LO, HI, MID, OUT)
  - default W and CNT_W constants
  - a pure function clmul_ref(x,y,n) used by both RTL assertions and the bench.
- One sub-module: clmul_half, a combinational H×H → (2H-1) carry-less multiplier (AND-array with XOR-reduced columns), instantiated exactly once.
- The overlap-sum XOR and the FSM stay in the top module.

Test Plan:
- Reset then a=0xFF, b=0xFF, out_ready=1 → out_valid 3 cycles after accept, y=0x5555, op_cnt=1.
- a=0x80, b=0x80 → y=0x4000. Then a=0x03, b=0x03 → y=0x0005, and in_ready is low for the 4 cycles between accepts.
- a=0x0F, b=0xF0 → y=0x0550. Then a=0x00, b=0xA7 → y=0x0000.
- Backpressure: out_ready=0 for 10 cycles after out_valid → y and out_valid hold, in_ready stays 0. out_ready=1 → single handshake, op_cnt increments by exactly 1.
- Assert rst while in HI state → all outputs at reset values asynchronously. A subsequent a=0x12, b=0x34 returns clmul_ref = 0x0328 with op_cnt=1.
- Random 10k operand pairs with random in_valid/out_ready gaps → y matches clmul_ref every handshake, no dropped or duplicated results. Preload op_cnt to 0xFFFF → wraps to 0x0000.
